dice_traffic_scheduler: RTL and testbench

Scheduler that shares the single 3-bit display of `dice_traffic_mux` between the traffic-light sequencer and dice-roll requests. It drives the mux `sel` and dice `button` inputs. Traffic owns the display by default. A dice roll is accepted only after traffic has held the display for a guaranteed minimum time. The roll runs the dice for a requested number of cycles, holds the throw on the display, then returns the display to traffic.

---
 rtl/dice_traffic_pkg.sv | 28 ++
 rtl/phase_counter.sv | 40 ++++
 rtl/dice_traffic_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_dice_traffic_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dice_traffic_pkg.sv
// Shared types and helpers for the dice/traffic display scheduler.
// State encoding, mux select values and roll-length clamp.
package dice_traffic_pkg;

  typedef enum logic [1:0] {
    TRAFFIC,
    ROLL,
    SETTLE,
    HOLD
  } state_e;

  localparam logic SEL_TRAFFIC = 1'b1;
  localparam logic SEL_DICE    = 1'b0;

  localparam int unsigned MAX_ROLL = 6;

  // A die has faces 1..6, so 0 and 7 fold to the nearest face
  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    logic [2:0] r;
    unique case (l)
      3'd0:    r = 3'd1;
      3'd7:    r = 3'd6;
      default: r = l;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with zero flag.
// Times both the ROLL and HOLD phases of the scheduler.
module phase_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over decrement; decrement stops at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/dice_traffic_scheduler.sv
// Shares the 3-bit display between traffic sequencer and dice.
// Traffic owns the display; rolls need a minimum traffic time first.
module dice_traffic_scheduler
  import dice_traffic_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned MIN_TRAFFIC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll_req,
  input  logic [2:0] roll_len,
  output logic       sel,
  output logic       button,
  output logic       roll_ack,
  output logic       roll_done,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned PC_MAX =
    (HOLD_CYCLES > MAX_ROLL) ? HOLD_CYCLES : MAX_ROLL;
  localparam int unsigned PC_W = $clog2(PC_MAX + 1);
  localparam int unsigned TC_W = $clog2(MIN_TRAFFIC + 1);

  localparam logic [TC_W-1:0] TC_MAX  = TC_W'(MIN_TRAFFIC);
  localparam logic [PC_W-1:0] HOLD_LD = PC_W'(HOLD_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  state_e          state_q, state_d;
  logic [TC_W-1:0] tcnt_q, tcnt_d;
  logic [TC_W-1:0] tcnt_inc;
  logic            pend_q, pend_d;
  logic [2:0]      plen_q, plen_d;
  logic            sel_q, sel_d;
  logic            button_q, button_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            busy_q, busy_d;

  logic            pc_load;
  logic            pc_dec;
  logic [PC_W-1:0] pc_val;
  logic [PC_W-1:0] pc_count;
  logic            pc_zero;
  logic [2:0]      req_len;
  logic            tc_full;
  logic            accept;

  phase_counter #(
    .W(PC_W)
  ) u_phase (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pc_load),
    .dec_i     (pc_dec),
    .load_val_i(pc_val),
    .count_o   (pc_count),
    .zero_o    (pc_zero)
  );

  // Traffic time is judged on the post-increment count
  always_comb begin
    tcnt_inc = (tcnt_q == TC_MAX) ? tcnt_q : tcnt_q + 1'b1;
    tc_full  = (tcnt_inc == TC_MAX);
    req_len  = clamp_len(roll_len);
    accept   = (state_q == TRAFFIC) && tc_full
               && (pend_q || roll_req);
  end

  // Phase sequencing, pending slot and registered outputs
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    pend_d  = pend_q;
    plen_d  = plen_q;
    pc_load = 1'b0;
    pc_dec  = 1'b0;
    pc_val  = '0;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    ovr_d   = 1'b0;

    unique case (state_q)
      TRAFFIC: begin
        tcnt_d = tcnt_inc;
        if (accept) begin
          state_d = ROLL;
          ack_d   = 1'b1;
          pc_load = 1'b1;
          if (pend_q) begin
            pc_val = PC_W'(plen_q) - 1'b1;
          end else begin
            pc_val = PC_W'(req_len) - 1'b1;
          end
        end
      end
      ROLL: begin
        if (pc_zero) begin
          state_d = SETTLE;
        end else begin
          pc_dec = 1'b1;
        end
      end
      SETTLE: begin
        state_d = HOLD;
        pc_load = 1'b1;
        pc_val  = HOLD_LD;
        done_d  = (HOLD_CYCLES == 1);
      end
      HOLD: begin
        if (pc_zero) begin
          state_d = TRAFFIC;
          tcnt_d  = '0;
        end else begin
          pc_dec = 1'b1;
          done_d = (pc_count == PC_ONE);
        end
      end
      default: begin
        state_d = TRAFFIC;
        tcnt_d  = '0;
      end
    endcase

    // A served pending slot refills from a simultaneous request
    if (accept) begin
      if (pend_q) begin
        pend_d = roll_req;
        if (roll_req) begin
          plen_d = req_len;
        end
      end
    end else if (roll_req) begin
      if (!pend_q) begin
        pend_d = 1'b1;
        plen_d = req_len;
      end else begin
        ovr_d = 1'b1;
      end
    end

    sel_d    = (state_d == TRAFFIC) ? SEL_TRAFFIC : SEL_DICE;
    button_d = (state_d == ROLL);
    busy_d   = (state_d != TRAFFIC) || pend_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= TRAFFIC;
      tcnt_q   <= '0;
      pend_q   <= 1'b0;
      plen_q   <= 3'd1;
      sel_q    <= SEL_TRAFFIC;
      button_q <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      pend_q   <= pend_d;
      plen_q   <= plen_d;
      sel_q    <= sel_d;
      button_q <= button_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign button    = button_q;
  assign roll_ack  = ack_q;
  assign roll_done = done_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dice_traffic_scheduler.sv
// Directed bench for dice_traffic_scheduler.
// Output vector order: sel, button, ack, done, overrun, busy.
module tb_dice_traffic_scheduler;

  localparam int HOLD = 8;

  logic       clk;
  logic       rst;
  logic       roll_req;
  logic [2:0] roll_len;
  logic       sel;
  logic       button;
  logic       roll_ack;
  logic       roll_done;
  logic       overrun;
  logic       busy;

  int tests;
  int fails;

  logic [5:0] obs;
  assign obs = {sel, button, roll_ack, roll_done, overrun, busy};

  dice_traffic_scheduler #(
    .HOLD_CYCLES(HOLD),
    .MIN_TRAFFIC(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .roll_req (roll_req),
    .roll_len (roll_len),
    .sel      (sel),
    .button   (button),
    .roll_ack (roll_ack),
    .roll_done(roll_done),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge
  task automatic check_roll(input int len, input logic busy_end);
    chk("ack", 6'b011001);
    for (int i = 1; i < len; i++) begin
      tick();
      chk("roll", 6'b010001);
    end
    tick();
    chk("settle", 6'b000001);
    for (int h = 1; h <= HOLD; h++) begin
      tick();
      if (h == HOLD) chk("hold_done", 6'b000101);
      else chk("hold", 6'b000001);
    end
    tick();
    chk("return", {5'b10000, busy_end});
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    roll_req = 1'b0;
    roll_len = 3'd0;

    #12;
    chk("reset", 6'b100000);
    step(2);
    chk("reset_held", 6'b100000);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", 6'b100000);
    end

    roll_req = 1'b1;
    roll_len = 3'd3;
    tick();
    roll_req = 1'b0;
    check_roll(3, 1'b0);

    step(4);
    roll_req = 1'b1;
    roll_len = 3'd0;
    tick();
    roll_req = 1'b0;
    check_roll(1, 1'b0);

    step(4);
    roll_req = 1'b1;
    roll_len = 3'd7;
    tick();
    roll_req = 1'b0;
    check_roll(6, 1'b0);

    step(4);
    roll_req = 1'b1;
    roll_len = 3'd2;
    tick();
    roll_req = 1'b0;
    chk("ovr_ack", 6'b011001);
    tick();
    chk("ovr_roll2", 6'b010001);
    tick();
    chk("ovr_settle", 6'b000001);
    tick();
    chk("ovr_hold1", 6'b000001);
    roll_req = 1'b1;
    roll_len = 3'd5;
    tick();
    chk("ovr_pend", 6'b000001);
    roll_len = 3'd4;
    tick();
    chk("ovr_pulse", 6'b000011);
    roll_req = 1'b0;
    tick();
    chk("ovr_once", 6'b000001);
    step(3);
    chk("ovr_hold7", 6'b000001);
    tick();
    chk("ovr_done", 6'b000101);
    tick();
    chk("ovr_ret", 6'b100001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovr_traffic", 6'b100001);
    end
    tick();
    check_roll(5, 1'b0);

    rst = 1'b0;
    #1;
    chk("rst2", 6'b100000);
    tick();
    rst = 1'b1;
    tick();
    roll_req = 1'b1;
    roll_len = 3'd2;
    tick();
    roll_req = 1'b0;
    chk("early_pend", 6'b100001);
    tick();
    chk("early_wait", 6'b100001);
    tick();
    check_roll(2, 1'b0);

    step(4);
    roll_req = 1'b1;
    roll_len = 3'd5;
    tick();
    roll_req = 1'b0;
    chk("mid_ack", 6'b011001);
    tick();
    chk("mid_roll2", 6'b010001);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_async", 6'b100000);
    step(2);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mid_after", 6'b100000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
